// File: rtl/enm_pkg.sv
// Shared types and defaults for the enemy path controller.
package enm_pkg;

  typedef enum logic [1:0] {
    P0   = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DEAD = 2'd3
  } phase_t;

  localparam int unsigned DEF_HI_TH = 80;
  localparam int unsigned DEF_LO_TH = 40;
  localparam int unsigned DEF_VSPD  = 2;
  localparam int unsigned DEF_HSPD  = 1;

  // HP to movement phase: zero is death, then thresholds split the three legs.
  function automatic phase_t hp_phase(input int unsigned hp,
                                      input int unsigned hi,
                                      input int unsigned lo);
    if (hp == 0)      return DEAD;
    else if (hp > hi) return P0;
    else if (hp > lo) return P1;
    else              return P2;
  endfunction

endpackage

// File: rtl/enm_path_chan.sv
// One enemy: phase FSM, anchor/dir for patrol, clamped stepper and death latch.
module enm_path_chan
  import enm_pkg::*;
#(
  parameter int unsigned       HP_W   = 7,
  parameter int unsigned       POS_W  = 10,
  parameter int unsigned       HI_TH  = DEF_HI_TH,
  parameter int unsigned       LO_TH  = DEF_LO_TH,
  parameter int unsigned       VSPD   = DEF_VSPD,
  parameter int unsigned       HSPD   = DEF_HSPD,
  parameter int unsigned       PATROL = 0,
  parameter logic [POS_W-1:0]  SX     = '0,
  parameter logic [POS_W-1:0]  SY     = '0,
  parameter logic [POS_W-1:0]  TY0    = '0,
  parameter logic [POS_W-1:0]  TX1    = '0,
  parameter logic [POS_W-1:0]  TY2    = '0
) (
  input  logic             clk22,
  input  logic             rst,
  input  logic             move_en,
  input  logic [HP_W-1:0]  hp,
  output logic             alive,
  output logic             die,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y
);

  localparam logic [POS_W-1:0] VSTEP = POS_W'(VSPD);
  localparam logic [POS_W-1:0] HSTEP = POS_W'(HSPD);

  // DEAD doubles as the sticky death flag: nothing leaves it except rst.
  phase_t           ph_q, ph_d, hp_ph;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] anc_q, anc_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             alive_q, alive_d, die_q, die_d;

  logic [POS_W-1:0] cur, tgt, spd, goal, diff, nxt;

  assign hp_ph = hp_phase(32'(hp), HI_TH, LO_TH);

  // Stepper operands for the axis owned by the current phase.
  always_comb begin
    cur = y_q;
    tgt = '0;
    spd = VSTEP;
    case (ph_q)
      P0:      tgt = TY0;
      P1:      begin cur = x_q; tgt = TX1; spd = HSTEP; end
      P2:      tgt = TY2;
      default: tgt = '0;
    endcase
    goal = dir_q ? anc_q : tgt;
    diff = (goal >= cur) ? goal - cur : cur - goal;
    if (diff <= spd)     nxt = goal;
    else if (goal > cur) nxt = cur + spd;
    else                 nxt = cur - spd;
  end

  // Next-state: death, phase entry (latch anchor, no move), then gated move.
  always_comb begin
    ph_d    = ph_q;
    dir_d   = dir_q;
    anc_d   = anc_q;
    x_d     = x_q;
    y_d     = y_q;
    alive_d = alive_q;
    die_d   = 1'b0;
    if (ph_q == DEAD || hp_ph == DEAD) begin
      ph_d    = DEAD;
      alive_d = 1'b0;
      die_d   = alive_q;
      x_d     = '0;
      y_d     = '0;
    end else begin
      alive_d = 1'b1;
      if (hp_ph != ph_q) begin
        ph_d  = hp_ph;
        dir_d = 1'b0;
        anc_d = (hp_ph == P1) ? x_q : y_q;
      end else if (move_en) begin
        if (cur == goal) begin
          if (PATROL != 0 && anc_q != tgt) dir_d = ~dir_q;
        end else if (ph_q == P1) begin
          x_d = nxt;
        end else begin
          y_d = nxt;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk22) begin
    if (rst) begin
      ph_q    <= P0;
      dir_q   <= 1'b0;
      anc_q   <= SY;
      x_q     <= SX;
      y_q     <= SY;
      alive_q <= 1'b0;
      die_q   <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      dir_q   <= dir_d;
      anc_q   <= anc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      alive_q <= alive_d;
      die_q   <= die_d;
    end
  end

  assign alive = alive_q;
  assign die   = die_q;
  assign x     = x_q;
  assign y     = y_q;

endmodule

// File: rtl/enm_path.sv
// N-enemy movement controller: independent per-enemy channels on clk22.
module enm_path
  import enm_pkg::*;
#(
  parameter int unsigned                  N_ENM   = 4,
  parameter int unsigned                  HP_W    = 7,
  parameter int unsigned                  POS_W   = 10,
  parameter int unsigned                  HI_TH   = DEF_HI_TH,
  parameter int unsigned                  LO_TH   = DEF_LO_TH,
  parameter int unsigned                  VSPD    = DEF_VSPD,
  parameter int unsigned                  HSPD    = DEF_HSPD,
  parameter int unsigned                  PATROL  = 0,
  parameter logic [N_ENM*POS_W-1:0]       START_X = {10'd340, 10'd240, 10'd140, 10'd40},
  parameter logic [N_ENM*POS_W-1:0]       START_Y = {10'd40, 10'd80, 10'd80, 10'd40},
  parameter logic [N_ENM*POS_W-1:0]       TGT_Y0  = {10'd20, 10'd220, 10'd20, 10'd220},
  parameter logic [N_ENM*POS_W-1:0]       TGT_X1  = {10'd260, 10'd320, 10'd60, 10'd120},
  parameter logic [N_ENM*POS_W-1:0]       TGT_Y2  = {10'd180, 10'd40, 10'd180, 10'd40}
) (
  input  logic                   clk22,
  input  logic                   rst,
  input  logic                   move_en,
  input  logic [N_ENM*HP_W-1:0]  enm_hp,
  output logic [N_ENM-1:0]       enm_alive,
  output logic [N_ENM-1:0]       enm_die,
  output logic [N_ENM*POS_W-1:0] enm_x,
  output logic [N_ENM*POS_W-1:0] enm_y
);

  for (genvar i = 0; i < N_ENM; i++) begin : g_chan
    enm_path_chan #(
      .HP_W  (HP_W),
      .POS_W (POS_W),
      .HI_TH (HI_TH),
      .LO_TH (LO_TH),
      .VSPD  (VSPD),
      .HSPD  (HSPD),
      .PATROL(PATROL),
      .SX    (START_X[i*POS_W +: POS_W]),
      .SY    (START_Y[i*POS_W +: POS_W]),
      .TY0   (TGT_Y0[i*POS_W +: POS_W]),
      .TX1   (TGT_X1[i*POS_W +: POS_W]),
      .TY2   (TGT_Y2[i*POS_W +: POS_W])
    ) u_chan (
      .clk22  (clk22),
      .rst    (rst),
      .move_en(move_en),
      .hp     (enm_hp[i*HP_W +: HP_W]),
      .alive  (enm_alive[i]),
      .die    (enm_die[i]),
      .x      (enm_x[i*POS_W +: POS_W]),
      .y      (enm_y[i*POS_W +: POS_W])
    );
  end

endmodule

// File: tb/tb_enm_path.sv
// Scoreboard bench for enm_path: one PATROL=0 and one PATROL=1 instance.
module tb_enm_path;

  localparam int unsigned PW = 10;

  logic        clk22 = 1'b0;
  logic        rst;
  logic        move_en;
  logic [27:0] hp, hp_p;
  logic [3:0]  alive, die, alive_p, die_p;
  logic [39:0] xs, ys, xs_p, ys_p;

  always #5 clk22 = ~clk22;

  enm_path #(.PATROL(0)) dut (
    .clk22(clk22), .rst(rst), .move_en(move_en), .enm_hp(hp),
    .enm_alive(alive), .enm_die(die), .enm_x(xs), .enm_y(ys)
  );

  enm_path #(.PATROL(1)) dut_p (
    .clk22(clk22), .rst(rst), .move_en(move_en), .enm_hp(hp_p),
    .enm_alive(alive_p), .enm_die(die_p), .enm_x(xs_p), .enm_y(ys_p)
  );

  typedef struct {
    string tag;
    int    inst;  // 0 = dut, 1 = dut_p
    int    sel;   // 0 x, 1 y, 2 alive, 3 die
    int    idx;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   sx[4] = '{40, 140, 240, 340};
  int   sy[4] = '{40, 80, 80, 40};

  task automatic chk(input string tag, input int got, input int want_v);
    vec_cnt++;
    if (got !== want_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want_v);
    end
  endtask

  function automatic int observe(input int inst, input int sel, input int idx);
    logic [39:0] x_v, y_v;
    logic [3:0]  a_v, d_v;
    x_v = (inst == 0) ? xs : xs_p;
    y_v = (inst == 0) ? ys : ys_p;
    a_v = (inst == 0) ? alive : alive_p;
    d_v = (inst == 0) ? die : die_p;
    case (sel)
      0:       return int'(x_v[idx*PW +: PW]);
      1:       return int'(y_v[idx*PW +: PW]);
      2:       return int'(a_v[idx]);
      default: return int'(d_v[idx]);
    endcase
  endfunction

  task automatic want(input string tag, input int inst, input int sel, input int idx, input int val);
    exp_t e;
    e.tag = tag; e.inst = inst; e.sel = sel; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk22);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.inst, e.sel, e.idx), e.val);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    move_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      want($sformatf("rst x%0d", i), 0, 0, i, sx[i]);
      want($sformatf("rst y%0d", i), 0, 1, i, sy[i]);
      want($sformatf("rst alive%0d", i), 0, 2, i, 0);
      want($sformatf("rst die%0d", i), 0, 3, i, 0);
    end
    want("rst p x0", 1, 0, 0, 40);
    want("rst p y0", 1, 1, 0, 40);
    tick();
    rst = 1'b0;
  endtask

  function automatic int patrol_y(input int k);
    int j;
    j = ((k - 1) % 182) + 1;
    if (j <= 90)       return 40 + 2 * j;
    else if (j == 91)  return 220;
    else if (j <= 181) return 220 - 2 * (j - 91);
    else               return 40;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b0;
    move_en = 1'b0;

    // Descent to P0 target, then P1 leg after hp drop; patrol instance alongside.
    hp   = {7'd100, 7'd100, 7'd100, 7'd100};
    hp_p = {7'd100, 7'd100, 7'd100, 7'd100};
    do_reset();
    move_en = 1'b1;
    for (int k = 1; k <= 370; k++) begin
      if (k == 96) hp[6:0] = 7'd60;
      if (k <= 95) begin
        want($sformatf("p0 y0 k=%0d", k), 0, 1, 0, (40 + 2 * k > 220) ? 220 : 40 + 2 * k);
        want($sformatf("p0 x0 k=%0d", k), 0, 0, 0, 40);
      end else begin
        want($sformatf("p1 y0 k=%0d", k), 0, 1, 0, 220);
        want($sformatf("p1 x0 k=%0d", k), 0, 0, 0, (40 + k - 96 > 120) ? 120 : 40 + k - 96);
      end
      if (k == 1) begin
        want("alive0 rise", 0, 2, 0, 1);
        want("die0 quiet", 0, 3, 0, 0);
      end
      want($sformatf("patrol y0 k=%0d", k), 1, 1, 0, patrol_y(k));
      tick();
    end

    // Enemy 1 in P1 with move_en every 4th cycle.
    hp = {7'd100, 7'd100, 7'd50, 7'd100};
    do_reset();
    n = 0;
    for (int c = 0; c <= 400; c++) begin
      move_en = (c % 4 == 3);
      if (move_en) n++;
      want($sformatf("gated x1 c=%0d", c), 0, 0, 1, (140 - n < 60) ? 60 : 140 - n);
      want($sformatf("gated y1 c=%0d", c), 0, 1, 1, 80);
      tick();
    end

    // Enemy 2 P2 leg then death; enemy 3 dead from reset release.
    hp = {7'd0, 7'd30, 7'd100, 7'd100};
    do_reset();
    move_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (k == 26) hp[20:14] = 7'd0;
      if (k == 28) hp[20:14] = 7'd30;
      if (k <= 25) begin
        want($sformatf("p2 y2 k=%0d", k), 0, 1, 2, (k == 1) ? 80 : ((80 - 2 * (k - 1) < 40) ? 40 : 80 - 2 * (k - 1)));
        want($sformatf("p2 x2 k=%0d", k), 0, 0, 2, 240);
        want($sformatf("p2 alive2 k=%0d", k), 0, 2, 2, 1);
      end else begin
        want($sformatf("dead x2 k=%0d", k), 0, 0, 2, 0);
        want($sformatf("dead y2 k=%0d", k), 0, 1, 2, 0);
        want($sformatf("dead alive2 k=%0d", k), 0, 2, 2, 0);
      end
      want($sformatf("die2 k=%0d", k), 0, 3, 2, (k == 26) ? 1 : 0);
      want($sformatf("alive3 k=%0d", k), 0, 2, 3, 0);
      want($sformatf("die3 k=%0d", k), 0, 3, 3, 0);
      want($sformatf("x3 k=%0d", k), 0, 0, 3, 0);
      want($sformatf("y3 k=%0d", k), 0, 1, 3, 0);
      tick();
    end

    // Enemy 3 reset mid-move.
    hp = {7'd90, 7'd100, 7'd100, 7'd100};
    do_reset();
    move_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      want($sformatf("mv y3 k=%0d", k), 0, 1, 3, 40 - 2 * k);
      want($sformatf("mv x3 k=%0d", k), 0, 0, 3, 340);
      want($sformatf("mv alive3 k=%0d", k), 0, 2, 3, 1);
      tick();
    end
    rst = 1'b1;
    want("midrst x3", 0, 0, 3, 340);
    want("midrst y3", 0, 1, 3, 40);
    want("midrst alive3", 0, 2, 3, 0);
    want("midrst die3", 0, 3, 3, 0);
    tick();
    rst = 1'b0;
    move_en = 1'b0;
    want("post x3", 0, 0, 3, 340);
    want("post y3", 0, 1, 3, 40);
    want("post alive3", 0, 2, 3, 1);
    tick();
    move_en = 1'b1;
    want("resume y3", 0, 1, 3, 38);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
